// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight destinations, picks forwarding sources and stalls ID on unready loads.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int PIPE_DEPTH         = 2,
    parameter int LOAD_LATENCY       = 2,
    localparam int SEL_W             = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
    input  logic                          id_ra_used,
    input  logic                          id_rb_used,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic                          id_wr_en,
    input  logic                          id_is_load,
    input  logic                          flush,
    output logic                          stall,
    output logic [SEL_W-1:0]              fwd_sel_a,
    output logic [SEL_W-1:0]              fwd_sel_b,
    output logic                          issue
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0]                   stall_cnt,
    output logic [31:0]                   flush_cnt
`endif
);

    logic [PIPE_DEPTH:1]           slot_valid_r;
    logic [PIPE_DEPTH:1]           slot_load_r;
    logic [REG_ADDRESS_LENGTH-1:0] slot_rd_r [1:PIPE_DEPTH];

    logic             hit_a_s, hit_b_s;
    logic             avail_a_s, avail_b_s;
    logic [SEL_W-1:0] sel_a_s, sel_b_s;
    logic             stall_s, issue_s;

    // Youngest-match search: scan oldest to youngest so the lowest slot index wins.
    always_comb begin
        hit_a_s   = 1'b0;
        hit_b_s   = 1'b0;
        avail_a_s = 1'b0;
        avail_b_s = 1'b0;
        sel_a_s   = {SEL_W{1'b0}};
        sel_b_s   = {SEL_W{1'b0}};
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (slot_valid_r[k] && id_ra_used && (slot_rd_r[k] == id_ra)) begin
                hit_a_s   = 1'b1;
                sel_a_s   = SEL_W'(k);
                avail_a_s = !slot_load_r[k] || (k >= LOAD_LATENCY);
            end else begin
                hit_a_s   = hit_a_s;
            end
            if (slot_valid_r[k] && id_rb_used && (slot_rd_r[k] == id_rb)) begin
                hit_b_s   = 1'b1;
                sel_b_s   = SEL_W'(k);
                avail_b_s = !slot_load_r[k] || (k >= LOAD_LATENCY);
            end else begin
                hit_b_s   = hit_b_s;
            end
        end
    end

    // Stall only for a real instruction that is not being squashed; flush wins.
    always_comb begin
        stall_s = id_valid && !flush && ((hit_a_s && !avail_a_s) || (hit_b_s && !avail_b_s));
        issue_s = id_valid && !stall_s && !flush;
    end

    assign stall     = stall_s;
    assign issue     = issue_s;
    assign fwd_sel_a = (hit_a_s && avail_a_s) ? sel_a_s : {SEL_W{1'b0}};
    assign fwd_sel_b = (hit_b_s && avail_b_s) ? sel_b_s : {SEL_W{1'b0}};

    // Tag pipeline shifts every cycle; a non-writing or non-issued slot-1 entry is a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid_r <= {PIPE_DEPTH{1'b0}};
            slot_load_r  <= {PIPE_DEPTH{1'b0}};
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                slot_rd_r[k] <= {REG_ADDRESS_LENGTH{1'b0}};
            end
        end else begin
            slot_valid_r[1] <= issue_s && id_wr_en;
            slot_load_r[1]  <= id_is_load;
            slot_rd_r[1]    <= id_rd;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                slot_valid_r[k] <= slot_valid_r[k-1];
                slot_load_r[k]  <= slot_load_r[k-1];
                slot_rd_r[k]    <= slot_rd_r[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush && id_valid && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDRESS_LENGTH, default 5, register address width.
REQ-002 SHALL have parameter PIPE_DEPTH, default 2, post-ID stages tracked; legal 2..6.
REQ-003 SHALL have parameter LOAD_LATENCY, default 2, first stage where load data is forwardable; legal 1..PIPE_DEPTH.
REQ-004 SHALL define SEL_W = clog2(PIPE_DEPTH+1) as a localparam.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 id_valid  input  1  valid instruction in ID.
REQ-008 id_ra, id_rb  input  REG_ADDRESS_LENGTH each  source addresses.
REQ-009 id_ra_used, id_rb_used  input  1 each  source actually read.
REQ-010 id_rd  input  REG_ADDRESS_LENGTH  destination address.
REQ-011 id_wr_en  input  1  instruction writes id_rd.
REQ-012 id_is_load  input  1  instruction is a DMEM/NIC load.
REQ-013 flush  input  1  branch taken; squash ID instruction.
REQ-014 stall  output  1  hold IF/ID and PC; insert bubble.
REQ-015 fwd_sel_a, fwd_sel_b  output  SEL_W each  0 = register file, k = forward from stage k.
REQ-016 issue  output  1  ID instruction advances this cycle.

Function
REQ-017 Tag pipeline: slots 1..PIPE_DEPTH, each holding {valid, rd, is_load}; all slots shift by one each cycle unconditionally; slot PIPE_DEPTH content retires.
REQ-018 issue = id_valid & ~stall & ~flush; combinational.
REQ-019 On issue with id_wr_en=1, slot 1 SHALL load {1, id_rd, id_is_load}; otherwise slot 1 SHALL load valid=0 (bubble).
REQ-020 Match for operand X: X_used=1 and a valid slot k has rd == X; only the youngest (lowest k) match counts.
REQ-021 Data in slot k is available when is_load=0 (any k), or is_load=1 and k >= LOAD_LATENCY.
REQ-022 fwd_sel_X SHALL be k when the youngest match is available, 0 when there is no match or X_used=0.
REQ-023 stall SHALL be 1 when id_valid=1, flush=0, and either operand's youngest match is unavailable; purely combinational.
REQ-024 While stall=1, fwd_sel_X is don't-care; the bench checks it only when issue=1.
REQ-025 flush has priority over stall: stall=0, issue=0, bubble pushed.
REQ-026 Both operands matching the same slot SHALL yield identical selects.
REQ-027 Retirement out of slot PIPE_DEPTH coincides with the register-file write edge; the next cycle, reads of that register SHALL select 0.
REQ-028 id_wr_en=0 instructions SHALL never create a match.

Reset
REQ-029 rst=0 SHALL asynchronously clear all slot valid bits and, if compiled in, all counters.
REQ-030 During and after reset with id_valid=0: stall=0, issue=0, fwd_sel_a=fwd_sel_b=0.
REQ-031 Reset asserted mid-stall SHALL drop stall in the same cycle, with no residual tags after release.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN SHALL gate performance counters.
REQ-033 With the macro: 32-bit outputs stall_cnt (+1 per stall cycle) and flush_cnt (+1 per flush with id_valid=1); both saturate at 0xFFFFFFFF.
REQ-034 Without the macro: these ports and registers SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Default params; issue ALU with rd=3; next cycle ra=3 used -> fwd_sel_a=1, stall=0, issue=1.
REQ-036 Issue load rd=4; next cycle rb=4 used -> stall=1 for exactly 1 cycle, then fwd_sel_b=2, issue=1.
REQ-037 ALU rd=5, then ALU rd=5, then read ra=5 -> fwd_sel_a=1 (youngest); three cycles after the last write, the same read -> fwd_sel_a=0.
REQ-038 Load rd=6 followed by a stalled read of r6 with flush=1 in the stall cycle -> stall=0, issue=0; slot 1 empty next cycle.
REQ-039 Load pending, stall=1; pulse rst=0 asynchronously -> stall=0 immediately; after release, read r6 -> fwd_sel=0.
REQ-040 With HAZARD_PERF_CNT_EN: scenario REQ-036 then one flush -> stall_cnt=1, flush_cnt=1; preload 0xFFFFFFFF and stall again -> stall_cnt holds at 0xFFFFFFFF.
